// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: one-cold column drive, synchronized row sense,
// full-matrix debounce with ghost rejection and one-shot b_0..b_f key pulses.
module keypad_scanner #(
    parameter int SCAN_DIV       = 256,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic       b_0,
    output logic       b_1,
    output logic       b_2,
    output logic       b_3,
    output logic       b_4,
    output logic       b_5,
    output logic       b_6,
    output logic       b_7,
    output logic       b_8,
    output logic       b_9,
    output logic       b_a,
    output logic       b_b,
    output logic       b_c,
    output logic       b_d,
    output logic       b_e,
    output logic       b_f,
    output logic       keyDown,
    output logic [3:0] keyCode
);

    localparam int         DIV_W = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_e;
    typedef enum logic {ST_IDLE, ST_HELD} state_e;

    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [15:0]      snap_q, snap_d;
    cls_e             prev_cls_q, prev_cls_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [3:0]       stable_q, stable_d;
    state_e           state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [15:0]      pulse_q, pulse_d;

    logic        sample, scan_end, same;
    logic [4:0]  ones;
    logic [3:0]  key;
    cls_e        cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            div_q       <= '0;
            col_q       <= '0;
            col_n_q     <= 4'b1110;
            snap_q      <= '0;
            prev_cls_q  <= CLS_NONE;
            prev_code_q <= '0;
            stable_q    <= '0;
            state_q     <= ST_IDLE;
            code_q      <= '0;
            pulse_q     <= '0;
        end else begin
            sync1_q     <= row_n;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            snap_q      <= snap_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            code_q      <= code_d;
            pulse_q     <= pulse_d;
        end
    end

    always_comb begin
        sample   = (div_q == DIV_W'(SCAN_DIV - 1));
        scan_end = sample && (col_q == 2'd3);
        div_d    = sample ? '0 : div_q + DIV_W'(1);
        col_d    = sample ? col_q + 2'd1 : col_q;
        col_n_d  = sample ? {col_n_q[2:0], col_n_q[3]} : col_n_q;

        snap_d = snap_q;
        if (sample) begin
            snap_d[{2'd0, col_q}] = ~sync2_q[0];
            snap_d[{2'd1, col_q}] = ~sync2_q[1];
            snap_d[{2'd2, col_q}] = ~sync2_q[2];
            snap_d[{2'd3, col_q}] = ~sync2_q[3];
        end

        // Classify the snapshot as it will stand after the column-3 sample,
        // so every scanDone-cycle output can be registered at that same edge.
        ones = '0;
        key  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                ones = ones + 5'd1;
                key  = 4'(i);
            end
        end
        if (ones == 5'd0)      cls = CLS_NONE;
        else if (ones == 5'd1) cls = CLS_ONE;
        else                   cls = CLS_MULTI;
        same = (cls == prev_cls_q) && ((cls != CLS_ONE) || (key == prev_code_q));

        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        state_d     = state_q;
        code_d      = code_q;
        pulse_d     = '0;

        if (scan_end) begin
            if (same) begin
                stable_d = (stable_q == DEB) ? stable_q : stable_q + 4'd1;
            end else begin
                stable_d    = 4'd1;
                prev_cls_d  = cls;
                prev_code_d = key;
            end
            if (stable_d == DEB) begin
                case (state_q)
                    ST_IDLE: if (cls == CLS_ONE) begin
                        state_d      = ST_HELD;
                        code_d       = key;
                        pulse_d[key] = 1'b1;
                    end
                    ST_HELD: if (cls == CLS_NONE) state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign col_n   = col_n_q;
    assign keyDown = (state_q == ST_HELD);
    assign keyCode = code_q;
    assign {b_f, b_e, b_d, b_c, b_b, b_a, b_9, b_8,
            b_7, b_6, b_5, b_4, b_3, b_2, b_1, b_0} = pulse_q;

endmodule
